// File: rtl/caf_freq_max_pkg.sv
// Shared CAF definitions: frame-peak FSM states and widths
// common to arg_max and caf_freq_max.
package caf_freq_max_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } caf_state_e;

  localparam int unsigned FREQ_BINS    = 8;
  localparam int unsigned FREQ_IDX_BITS = 3;
  localparam int unsigned INDEX_BITS   = 4;
  localparam int unsigned OUT_MAX_BITS = 4;

endpackage

// File: rtl/caf_freq_max_cmp.sv
// Strict greater-than comparator cell with load enable;
// 'first' forces a load regardless of the stored value.
module caf_freq_max_cmp #(
  parameter int unsigned w = 4
) (
  input  logic         en,
  input  logic         first,
  input  logic [w-1:0] in_val,
  input  logic [w-1:0] best_val,
  output logic         take
);

  always_comb begin
    take = en & (first | (in_val > best_val));
  end

endmodule

// File: rtl/caf_freq_max.sv
// CAF frame peak: global max over freq_bins arg_max results,
// emitted with lag, bin index and threshold detect.
module caf_freq_max
  import caf_freq_max_pkg::*;
#(
  parameter int unsigned freq_bins       = FREQ_BINS,
  parameter int unsigned freq_index_bits = FREQ_IDX_BITS,
  parameter int unsigned index_bits      = INDEX_BITS,
  parameter int unsigned max_bits        = OUT_MAX_BITS,
  parameter logic [max_bits-1:0] threshold = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_axis_tvalid,
  input  logic [max_bits-1:0]        in_max,
  input  logic [index_bits-1:0]      in_index,
  output logic                       s_axis_tready,
  input  logic                       m_axis_tready,
  output logic [max_bits-1:0]        out_max,
  output logic [index_bits-1:0]      lag_index,
  output logic [freq_index_bits-1:0] freq_index,
  output logic                       detected,
  output logic                       s_axis_tvalid
);

  localparam logic [freq_index_bits-1:0] LAST_BIN =
    freq_index_bits'(freq_bins - 1);

  caf_state_e state_q, state_d;
  logic [freq_index_bits-1:0] bin_cnt_q, bin_cnt_d;
  logic [max_bits-1:0]        best_max_q, best_max_d;
  logic [index_bits-1:0]      best_lag_q, best_lag_d;
  logic [freq_index_bits-1:0] best_bin_q, best_bin_d;
  logic [max_bits-1:0]        out_max_q, out_max_d;
  logic [index_bits-1:0]      lag_q, lag_d;
  logic [freq_index_bits-1:0] freq_q, freq_d;
  logic                       det_q, det_d;
  logic                       valid_q, valid_d;
  logic                       ready_q, ready_d;

  logic                       accept;
  logic                       take;
  logic [max_bits-1:0]        cand_max;
  logic [index_bits-1:0]      cand_lag;
  logic [freq_index_bits-1:0] cand_bin;
  logic [max_bits:0]          thr_diff;

  assign accept = m_axis_tvalid & ready_q;

  caf_freq_max_cmp #(
    .w(max_bits)
  ) u_cmp (
    .en      (accept),
    .first   (bin_cnt_q == '0),
    .in_val  (in_max),
    .best_val(best_max_q),
    .take    (take)
  );

  always_comb begin
    cand_max = take ? in_max   : best_max_q;
    cand_lag = take ? in_index : best_lag_q;
    cand_bin = take ? bin_cnt_q : best_bin_q;
    // sign bit of the widened difference gives the unsigned >= test
    thr_diff = {1'b0, cand_max} - {1'b0, threshold};
  end

  always_comb begin
    state_d    = state_q;
    bin_cnt_d  = bin_cnt_q;
    best_max_d = best_max_q;
    best_lag_d = best_lag_q;
    best_bin_d = best_bin_q;
    out_max_d  = out_max_q;
    lag_d      = lag_q;
    freq_d     = freq_q;
    det_d      = det_q;
    valid_d    = valid_q;
    unique case (1'b1)
      (state_q == COLLECT): begin
        if (accept) begin
          best_max_d = cand_max;
          best_lag_d = cand_lag;
          best_bin_d = cand_bin;
          if (bin_cnt_q == LAST_BIN) begin
            out_max_d = cand_max;
            lag_d     = cand_lag;
            freq_d    = cand_bin;
            det_d     = ~thr_diff[max_bits];
            valid_d   = 1'b1;
            bin_cnt_d = '0;
            state_d   = EMIT;
          end else begin
            bin_cnt_d = bin_cnt_q + 1'b1;
          end
        end
      end
      (state_q == EMIT): begin
        if (valid_q & m_axis_tready) begin
          valid_d = 1'b0;
          state_d = COLLECT;
        end
      end
      default: ;
    endcase
    ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      bin_cnt_q  <= '0;
      best_max_q <= '0;
      best_lag_q <= '0;
      best_bin_q <= '0;
      out_max_q  <= '0;
      lag_q      <= '0;
      freq_q     <= '0;
      det_q      <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_cnt_q  <= bin_cnt_d;
      best_max_q <= best_max_d;
      best_lag_q <= best_lag_d;
      best_bin_q <= best_bin_d;
      out_max_q  <= out_max_d;
      lag_q      <= lag_d;
      freq_q     <= freq_d;
      det_q      <= det_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign s_axis_tvalid = valid_q;
  assign out_max       = out_max_q;
  assign lag_index     = lag_q;
  assign freq_index    = freq_q;
  assign detected      = det_q;

endmodule

// File: tb/tb_caf_freq_max.sv
// Bench for caf_freq_max: 4-bin/threshold-8 and 1-bin instances,
// directed scenarios plus random frames against a reference model.
module tb_caf_freq_max;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       vld4, mrdy4, sr4, dt4, sv4;
  logic [3:0] mx4, ix4, om4, li4;
  logic [2:0] fi4;
  logic       vld1, mrdy1, sr1, dt1, sv1;
  logic [3:0] mx1, ix1, om1, li1;
  logic [2:0] fi1;

  int n_chk  = 0;
  int n_fail = 0;

  caf_freq_max #(
    .freq_bins(4), .freq_index_bits(3), .index_bits(4),
    .max_bits(4), .threshold(4'd8)
  ) dut4 (
    .clk(clk), .rst(rst), .m_axis_tvalid(vld4), .in_max(mx4),
    .in_index(ix4), .s_axis_tready(sr4), .m_axis_tready(mrdy4),
    .out_max(om4), .lag_index(li4), .freq_index(fi4),
    .detected(dt4), .s_axis_tvalid(sv4)
  );

  caf_freq_max #(
    .freq_bins(1), .freq_index_bits(3), .index_bits(4),
    .max_bits(4), .threshold(4'd0)
  ) dut1 (
    .clk(clk), .rst(rst), .m_axis_tvalid(vld1), .in_max(mx1),
    .in_index(ix1), .s_axis_tready(sr1), .m_axis_tready(mrdy1),
    .out_max(om1), .lag_index(li1), .freq_index(fi1),
    .detected(dt1), .s_axis_tvalid(sv1)
  );

  // present one result to dut4; returns at the negedge after accept
  task automatic push4(input logic [3:0] m, input logic [3:0] i);
    int w = 0;
    while (!sr4 && w < 40) begin
      vld4 = 1'b0;
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (sr4 !== 1'b1) begin
      n_fail++;
      $display("FAIL push4_ready got=%b want=1", sr4);
    end
    vld4 = 1'b1; mx4 = m; ix4 = i;
    @(negedge clk);
  endtask

  task automatic push1(input logic [3:0] m, input logic [3:0] i);
    int w = 0;
    while (!sr1 && w < 40) begin
      vld1 = 1'b0;
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (sr1 !== 1'b1) begin
      n_fail++;
      $display("FAIL push1_ready got=%b want=1", sr1);
    end
    vld1 = 1'b1; mx1 = m; ix1 = i;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({sr4, sv4, om4, li4, fi4, dt4} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset4 got=%h want=0",
               {sr4, sv4, om4, li4, fi4, dt4});
    end
    n_chk++;
    if ({sr1, sv1, om1, li1, fi1, dt1} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset1 got=%h want=0",
               {sr1, sv1, om1, li1, fi1, dt1});
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({sr4, sr1} !== 2'b11) begin
      n_fail++;
      $display("FAIL ready_after_reset got=%b want=11", {sr4, sr1});
    end
  endtask

  task automatic test_basic();
    mrdy4 = 1'b1;
    push4(4'd3, 4'd1); push4(4'd9, 4'd2);
    push4(4'd5, 4'd3); push4(4'd7, 4'd4);
    vld4 = 1'b0;
    n_chk++;
    if ({sr4, sv4, om4, li4, fi4, dt4} !== {1'b0, 1'b1, 4'd9, 4'd2, 3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_result got=%h want=%h",
        {sr4, sv4, om4, li4, fi4, dt4},
        {1'b0, 1'b1, 4'd9, 4'd2, 3'd1, 1'b1});
    end
    @(negedge clk);
    n_chk++;
    if ({sv4, sr4, om4} !== {1'b0, 1'b1, 4'd9}) begin
      n_fail++;
      $display("FAIL basic_one_cycle got=%h want=%h",
               {sv4, sr4, om4}, {1'b0, 1'b1, 4'd9});
    end
  endtask

  task automatic test_tie();
    push4(4'd6, 4'd10); push4(4'd6, 4'd11);
    push4(4'd2, 4'd12); push4(4'd6, 4'd13);
    vld4 = 1'b0;
    n_chk++;
    if ({sv4, om4, li4, fi4, dt4} !== {1'b1, 4'd6, 4'd10, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL tie got=%h want=%h", {sv4, om4, li4, fi4, dt4},
               {1'b1, 4'd6, 4'd10, 3'd0, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    mrdy4 = 1'b0;
    push4(4'd1, 4'd1); push4(4'd2, 4'd2);
    push4(4'd3, 4'd3); push4(4'd4, 4'd4);
    for (int k = 0; k < 5; k++) begin
      vld4 = 1'b1; mx4 = 4'd15; ix4 = 4'd15;
      n_chk++;
      if ({sr4, sv4, om4, li4, fi4, dt4} !== {1'b0, 1'b1, 4'd4, 4'd4, 3'd3, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got=%h want=%h", k,
          {sr4, sv4, om4, li4, fi4, dt4},
          {1'b0, 1'b1, 4'd4, 4'd4, 3'd3, 1'b0});
      end
      @(negedge clk);
    end
    vld4 = 1'b0;
    mrdy4 = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({sv4, sr4} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release got=%b want=01", {sv4, sr4});
    end
    push4(4'd5, 4'd1); push4(4'd5, 4'd2);
    push4(4'd5, 4'd3); push4(4'd5, 4'd4);
    vld4 = 1'b0;
    n_chk++;
    if ({sv4, om4, li4, fi4} !== {1'b1, 4'd5, 4'd1, 3'd0}) begin
      n_fail++;
      $display("FAIL bp_no_consume got=%h want=%h",
               {sv4, om4, li4, fi4}, {1'b1, 4'd5, 4'd1, 3'd0});
    end
    @(negedge clk);
  endtask

  task automatic test_threshold();
    push4(4'd8, 4'd3); push4(4'd1, 4'd4);
    push4(4'd2, 4'd5); push4(4'd3, 4'd6);
    vld4 = 1'b0;
    n_chk++;
    if ({sv4, om4, li4, dt4} !== {1'b1, 4'd8, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL thr_equal got=%h want=%h",
               {sv4, om4, li4, dt4}, {1'b1, 4'd8, 4'd3, 1'b1});
    end
    @(negedge clk);
    push4(4'd7, 4'd9); push4(4'd7, 4'd8);
    push4(4'd0, 4'd7); push4(4'd1, 4'd6);
    vld4 = 1'b0;
    n_chk++;
    if ({sv4, om4, li4, fi4, dt4} !== {1'b1, 4'd7, 4'd9, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL thr_below got=%h want=%h", {sv4, om4, li4, fi4, dt4},
               {1'b1, 4'd7, 4'd9, 3'd0, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    push4(4'd14, 4'd1); push4(4'd13, 4'd2);
    vld4 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({sr4, sv4, om4} !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_reset got=%h want=0", {sr4, sv4, om4});
    end
    rst = 1'b0;
    @(negedge clk);
    push4(4'd1, 4'd5); push4(4'd2, 4'd6);
    push4(4'd15, 4'd7); push4(4'd4, 4'd8);
    vld4 = 1'b0;
    n_chk++;
    if ({sv4, om4, li4, fi4, dt4} !== {1'b1, 4'd15, 4'd7, 3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL fresh_frame got=%h want=%h", {sv4, om4, li4, fi4, dt4},
               {1'b1, 4'd15, 4'd7, 3'd2, 1'b1});
    end
    @(negedge clk);
  endtask

  task automatic test_single_bin();
    mrdy1 = 1'b0;
    push1(4'd4, 4'd3);
    vld1 = 1'b0;
    n_chk++;
    if ({sv1, om1, li1, fi1, dt1} !== {1'b1, 4'd4, 4'd3, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_a got=%h want=%h", {sv1, om1, li1, fi1, dt1},
               {1'b1, 4'd4, 4'd3, 3'd0, 1'b1});
    end
    mrdy1 = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({sv1, sr1} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_hs got=%b want=01", {sv1, sr1});
    end
    repeat (3) @(negedge clk);
    push1(4'd10, 4'd9);
    vld1 = 1'b0;
    n_chk++;
    if ({sv1, om1, li1, fi1, dt1} !== {1'b1, 4'd10, 4'd9, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_b got=%h want=%h", {sv1, om1, li1, fi1, dt1},
               {1'b1, 4'd10, 4'd9, 3'd0, 1'b1});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] vals[4];
    logic [3:0] lags[4];
    logic [3:0] e_max, e_lag;
    logic [2:0] e_bin;
    logic       e_det;
    mrdy4 = 1'b0;
    for (int f = 0; f < 25; f++) begin
      for (int b = 0; b < 4; b++) begin
        vals[b] = 4'($urandom_range(0, 15));
        lags[b] = 4'($urandom_range(0, 15));
      end
      // reference: first bin holding the largest magnitude
      e_bin = 3'd0;
      for (int b = 1; b < 4; b++)
        if (vals[b] > vals[e_bin]) e_bin = 3'(b);
      e_max = vals[e_bin];
      e_lag = lags[e_bin];
      e_det = (e_max >= 4'd8);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 2) == 0) begin
          vld4 = 1'b0;
          repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        push4(vals[b], lags[b]);
      end
      vld4 = 1'($urandom_range(0, 1));
      mx4 = 4'd15; ix4 = 4'd0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_chk++;
      if ({sr4, sv4, om4, li4, fi4, dt4} !== {1'b0, 1'b1, e_max, e_lag, e_bin, e_det}) begin
        n_fail++;
        $display("FAIL rand_frame f=%0d got=%h want=%h", f,
          {sr4, sv4, om4, li4, fi4, dt4},
          {1'b0, 1'b1, e_max, e_lag, e_bin, e_det});
      end
      vld4 = 1'b0;
      mrdy4 = 1'b1;
      @(negedge clk);
      mrdy4 = 1'b0;
      n_chk++;
      if ({sv4, sr4, om4} !== {1'b0, 1'b1, e_max}) begin
        n_fail++;
        $display("FAIL rand_hs f=%0d got=%h want=%h", f,
                 {sv4, sr4, om4}, {1'b0, 1'b1, e_max});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vld4 = 1'b0; mx4 = '0; ix4 = '0; mrdy4 = 1'b0;
    vld1 = 1'b0; mx1 = '0; ix1 = '0; mrdy1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_tie();
    test_backpressure();
    test_threshold();
    test_reset_mid_frame();
    test_single_bin();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
